vending_controller_n: RTL and testbench

VENDING_CONTROLLER_N -- requirements
Module: vending_controller_n

---
 rtl/vending_controller_n.sv | 161 ++++++++++++++++
 tb/tb_vending_controller_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vending_controller_n.sv
// Credit/vend/refund controller: registered pulses, saturating credit, timed ERROR hold.
// Optional per-item stock counting and SOLDOUT state when STOCK_COUNT_EN is defined.
module vending_controller_n #(
  parameter int                         BAL_W      = 8,
  parameter int                         N_ITEMS    = 4,
  parameter logic [N_ITEMS*BAL_W-1:0]   COSTS      = {8'd5, 8'd4, 8'd3, 8'd2},
  parameter int                         ERR_HOLD   = 4,
  parameter int                         STOCK_INIT = 3,
  localparam int                        IDX_W      = $clog2(N_ITEMS)
) (
  input  logic               clock_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [BAL_W-1:0]   balance_i,
  input  logic [N_ITEMS-1:0] item_sel_i,
  input  logic               refund_req_i,
  output logic [BAL_W-1:0]   credit_o,
  output logic [2:0]         state_o,
  output logic               vend_o,
  output logic [IDX_W-1:0]   vend_idx_o,
  output logic               refund_o,
  output logic [BAL_W-1:0]   refund_amt_o
);

  localparam int HOLD_W = $clog2(ERR_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CREDIT  = 3'd1,
    S_VEND    = 3'd2,
    S_ERROR   = 3'd3,
    S_SOLDOUT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BAL_W-1:0]   credit_q, credit_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               vend_q, vend_d;
  logic [IDX_W-1:0]   vend_idx_q, vend_idx_d;
  logic               refund_q, refund_d;
  logic [BAL_W-1:0]   refund_amt_q, refund_amt_d;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_onehot;
  logic [BAL_W-1:0]   sel_cost;
  logic [BAL_W:0]     sum;
  logic [BAL_W-1:0]   sat;
  logic               sold_out;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (item_sel_i[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_onehot = (item_sel_i != '0) && ((item_sel_i & (item_sel_i - 1'b1)) == '0);
  assign sel_cost   = COSTS[sel_idx*BAL_W +: BAL_W];
  assign sum        = {1'b0, credit_q} + {1'b0, balance_i};
  assign sat        = sum[BAL_W] ? '1 : sum[BAL_W-1:0];

`ifdef STOCK_COUNT_EN
  localparam int STK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic [STK_W-1:0] stock_q [N_ITEMS];

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STK_W'(STOCK_INIT);
    end else if (vend_d) begin
      stock_q[vend_idx_d] <= stock_q[vend_idx_d] - STK_W'(1);
    end
  end

  assign sold_out = (stock_q[sel_idx] == '0);
`else
  // Unlimited stock: an item can never be sold out.
  assign sold_out = (STOCK_INIT < 0);
`endif

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    hold_d       = hold_q;
    vend_d       = 1'b0;
    vend_idx_d   = '0;
    refund_d     = 1'b0;
    refund_amt_d = '0;
    if (refund_req_i) begin
      refund_d     = (credit_q != '0);
      refund_amt_d = credit_q;
      credit_d     = '0;
      state_d      = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_i && balance_i != '0) begin
            credit_d = balance_i;
            state_d  = S_CREDIT;
          end
        end
        S_CREDIT, S_VEND: begin
          state_d = (state_q == S_VEND && credit_q == '0) ? S_IDLE : S_CREDIT;
          if (load_i) begin
            credit_d = sat;
            state_d  = (state_q == S_CREDIT || sat != '0) ? S_CREDIT : S_IDLE;
          end else if (item_sel_i != '0) begin
            hold_d = HOLD_W'(ERR_HOLD - 1);
            if (!sel_onehot) begin
              state_d = S_ERROR;
            end else if (sold_out) begin
              state_d = S_SOLDOUT;
            end else if (credit_q < sel_cost) begin
              state_d = S_ERROR;
            end else begin
              credit_d   = credit_q - sel_cost;
              vend_d     = 1'b1;
              vend_idx_d = sel_idx;
              state_d    = S_VEND;
            end
          end
        end
        S_ERROR, S_SOLDOUT: begin
          if (hold_q == '0) state_d = S_CREDIT;
          else              hold_d  = hold_q - 1'b1;
        end
        default: begin
          state_d  = S_IDLE;
          credit_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      hold_q       <= '0;
      vend_q       <= 1'b0;
      vend_idx_q   <= '0;
      refund_q     <= 1'b0;
      refund_amt_q <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      hold_q       <= hold_d;
      vend_q       <= vend_d;
      vend_idx_q   <= vend_idx_d;
      refund_q     <= refund_d;
      refund_amt_q <= refund_amt_d;
    end
  end

  assign credit_o     = credit_q;
  assign state_o      = state_q;
  assign vend_o       = vend_q;
  assign vend_idx_o   = vend_idx_q;
  assign refund_o     = refund_q;
  assign refund_amt_o = refund_amt_q;

endmodule

// File: tb/tb_vending_controller_n.sv
// Directed and randomized bench for vending_controller_n against an arithmetic reference model.
module tb_vending_controller_n;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       load = 1'b0;
  logic [7:0] balance_in = '0;
  logic [3:0] item_sel = '0;
  logic       refund_req = 1'b0;
  logic [7:0] credit;
  logic [2:0] state;
  logic       vend;
  logic [1:0] vend_idx;
  logic       refund;
  logic [7:0] refund_amt;

  int checks = 0;
  int errors = 0;

  vending_controller_n dut (
    .clock_i(clock), .clear_i(clear), .load_i(load), .balance_i(balance_in),
    .item_sel_i(item_sel), .refund_req_i(refund_req), .credit_o(credit),
    .state_o(state), .vend_o(vend), .vend_idx_o(vend_idx), .refund_o(refund),
    .refund_amt_o(refund_amt)
  );

  always #5 clock = ~clock;

  // Reference model: modes 0 idle, 1 credit, 2 just vended, 3 error, 4 sold out.
  int price [4] = '{2, 3, 4, 5};
  int m_mode, m_credit, m_hold, m_vend, m_idx, m_ref, m_amt;
  int m_stock [4];

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_hold = 0;
    m_vend = 0; m_idx = 0; m_ref = 0; m_amt = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;
  endtask

  task automatic model_step(input int ld, input int bal, input logic [3:0] sel, input int rr);
    int item;
    m_vend = 0; m_idx = 0; m_ref = 0; m_amt = 0;
    item = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) item = i;
    if (rr != 0) begin
      if (m_credit > 0) begin m_ref = 1; m_amt = m_credit; end
      m_credit = 0;
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (ld != 0 && bal > 0) begin m_credit = bal; m_mode = 1; end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (ld != 0) begin
        m_credit = (m_credit + bal > 255) ? 255 : m_credit + bal;
        if (m_mode == 2) m_mode = (m_credit > 0) ? 1 : 0;
      end else if ($countones(sel) > 1) begin
        m_mode = 3; m_hold = 4;
`ifdef STOCK_COUNT_EN
      end else if ($countones(sel) == 1 && m_stock[item] == 0) begin
        m_mode = 4; m_hold = 4;
`endif
      end else if ($countones(sel) == 1 && m_credit < price[item]) begin
        m_mode = 3; m_hold = 4;
      end else if ($countones(sel) == 1) begin
        m_credit = m_credit - price[item];
        m_stock[item] = m_stock[item] - 1;
        m_vend = 1; m_idx = item; m_mode = 2;
      end else if (m_mode == 2) begin
        m_mode = (m_credit > 0) ? 1 : 0;
      end
    end else begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_mode = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state), m_mode);
    check({tag, ".credit"}, 32'(credit), m_credit);
    check({tag, ".vend"}, 32'(vend), m_vend);
    check({tag, ".vend_idx"}, 32'(vend_idx), m_idx);
    check({tag, ".refund"}, 32'(refund), m_ref);
    check({tag, ".refund_amt"}, 32'(refund_amt), m_amt);
  endtask

  task automatic step(input string tag, input logic ld, input logic [7:0] bal,
                      input logic [3:0] sel, input logic rr);
    load = ld; balance_in = bal; item_sel = sel; refund_req = rr;
    @(posedge clock);
    model_step(int'(ld), int'(bal), sel, int'(rr));
    #1;
    check_all(tag);
  endtask

  // Asynchronous clear between edges; outputs must drop without waiting for a clock.
  task automatic async_clear(input string tag);
    #1 clear = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    clear = 1'b0;
    @(negedge clock);

    step("r032_load", 1'b1, 8'd7, 4'b0000, 1'b0);
    check("r032_credit7", 32'(credit), 7);
    step("r032_buy", 1'b0, 8'd0, 4'b0010, 1'b0);
    check("r032_vend", 32'(vend), 1);
    check("r032_idx", 32'(vend_idx), 1);
    check("r032_credit4", 32'(credit), 4);
    check("r032_state_vend", 32'(state), 2);
    step("r032_after", 1'b0, 8'd0, 4'b0000, 1'b0);
    check("r032_state_credit", 32'(state), 1);

    step("r033_sel", 1'b0, 8'd0, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("r033_err", 32'(state), 3);
      step("r033_hold", 1'b1, 8'd9, 4'b0001, 1'b0);
    end
    check("r033_err_last", 32'(state), 3);
    check("r033_credit", 32'(credit), 4);
    step("r033_exit", 1'b0, 8'd0, 4'b0000, 1'b0);
    check("r033_back", 32'(state), 1);

    step("r034_clr", 1'b0, 8'd0, 4'b0000, 1'b1);
    step("r034_l250", 1'b1, 8'd250, 4'b0000, 1'b0);
    step("r034_l10", 1'b1, 8'd10, 4'b0000, 1'b0);
    check("r034_sat", 32'(credit), 255);
    step("r034_ref", 1'b0, 8'd0, 4'b0000, 1'b1);
    check("r034_amt", 32'(refund_amt), 255);
    check("r034_idle", 32'(state), 0);

    step("r035_l6", 1'b1, 8'd6, 4'b0000, 1'b0);
    step("r035_pri", 1'b1, 8'd3, 4'b0001, 1'b1);
    check("r035_amt", 32'(refund_amt), 6);
    check("r035_novend", 32'(vend), 0);
    check("r035_credit", 32'(credit), 0);

    step("r036_l9", 1'b1, 8'd9, 4'b0000, 1'b0);
    step("r036_multi", 1'b0, 8'd0, 4'b0011, 1'b0);
    check("r036_err", 32'(state), 3);
    check("r036_credit", 32'(credit), 9);
    async_clear("r036_clear");
    check("r036_credit0", 32'(credit), 0);

`ifdef STOCK_COUNT_EN
    step("r037_l8", 1'b1, 8'd8, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("r037_buy", 1'b0, 8'd0, 4'b0001, 1'b0);
      check("r037_vend", 32'(vend), 1);
    end
    step("r037_empty", 1'b0, 8'd0, 4'b0001, 1'b0);
    check("r037_soldout", 32'(state), 4);
    check("r037_credit", 32'(credit), 2);
    async_clear("r037_clear");
`endif

    for (int n = 0; n < 600; n++) begin
      logic       ld, rr;
      logic [7:0] bal;
      logic [3:0] sel;
      int         r;
      ld  = ($urandom_range(0, 9) < 3);
      rr  = ($urandom_range(0, 99) < 6);
      bal = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 12));
      r   = $urandom_range(0, 9);
      if (r < 4)      sel = 4'b0000;
      else if (r < 9) sel = 4'(1 << $urandom_range(0, 3));
      else            sel = 4'($urandom_range(0, 15));
      step("rand", ld, bal, sel, rr);
      if ($urandom_range(0, 199) == 0) async_clear("rand_clear");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
